// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI bus arbiter slice.
// Window decode and size normalisation helpers live here so every user agrees on them.
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic SEL_FLASH = 1'b0;
    localparam logic SEL_PSRAM = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int WIN_BITS = 24;

    // True when addr falls in [base, base + 2^WIN_BITS); wrap-safe via the offset.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return (off[31:WIN_BITS] == {(32-WIN_BITS){1'b0}});
    endfunction

    // The engine knows only byte/half/word; the reserved encoding collapses to word.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        logic [1:0] res;
        case (size)
            SZ_B:    res = SZ_B;
            SZ_H:    res = SZ_H;
            default: res = SZ_W;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/qspi_bus_arbiter_rr_arb2.sv
// Two-input round-robin picker. Bit 0 is the instruction port, bit 1 the data port.
// The history bit only moves when the caller actually takes a grant.
module rr_arb2
    import qspi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    port_t last_grant_r;

    // Pick the single requester, or on a tie the port that did not win last time.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_r == PORT_D) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // History register; resets to data so the instruction port wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= PORT_D;
        end else if (en && (gnt != 2'b00)) begin
            last_grant_r <= gnt[1] ? PORT_D : PORT_I;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Arbiter and sequencer in front of the shared quad-SPI engine: decodes, grants
// round-robin, issues one engine transaction per grant and enforces the CS idle gap.
module qspi_bus_arbiter
    import qspi_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] PSRAM_BASE_ADDR = 32'h0100_0000,
    parameter int unsigned CS_GAP          = 2
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        e_start,
    output logic        e_sel,
    output logic [23:0] e_addr,
    output logic        e_we,
    output logic [31:0] e_wdata,
    output logic [1:0]  e_size,
    input  logic        e_done,
    input  logic [31:0] e_rdata,
    output logic        err
);

    localparam logic       HAS_GAP  = (CS_GAP != 0);
    localparam logic [3:0] GAP_LOAD = 4'(CS_GAP - 1);

    state_t      state_r;
    port_t       gnt_port_r;
    logic [3:0]  gap_cnt_r;

    logic [1:0]  req_s;
    logic [1:0]  gnt_s;
    logic        arb_en_s;
    logic        pick_d_s;
    logic [31:0] req_addr_s;
    logic        req_we_s;
    logic [31:0] req_wdata_s;
    logic [1:0]  req_size_s;
    logic        hit_flash_s;
    logic        hit_psram_s;
    logic        req_sel_s;
    logic        illegal_s;

    assign req_s    = {d_req, i_req};
    assign arb_en_s = (state_r == ST_IDLE);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_s),
        .en    (arb_en_s),
        .gnt   (gnt_s)
    );

    // Payload and decode of whichever port the arbiter is offering this cycle.
    always_comb begin
        pick_d_s    = gnt_s[1];
        req_addr_s  = pick_d_s ? d_addr : i_addr;
        req_we_s    = pick_d_s & d_we;
        req_wdata_s = pick_d_s ? d_wdata : 32'h0000_0000;
        req_size_s  = pick_d_s ? norm_size(d_size) : SZ_W;
        hit_flash_s = in_window(req_addr_s, FLASH_BASE_ADDR);
        hit_psram_s = in_window(req_addr_s, PSRAM_BASE_ADDR);
        req_sel_s   = hit_flash_s ? SEL_FLASH : SEL_PSRAM;
        illegal_s   = !(hit_flash_s || hit_psram_s) || (hit_flash_s && req_we_s);
    end

    // Sequencer: state, gap counter, latched engine payload and requester responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_port_r <= PORT_D;
            gap_cnt_r  <= 4'd0;
            i_rdata    <= 32'h0000_0000;
            i_done     <= 1'b0;
            d_rdata    <= 32'h0000_0000;
            d_done     <= 1'b0;
            e_start    <= 1'b0;
            e_sel      <= 1'b0;
            e_addr     <= 24'h00_0000;
            e_we       <= 1'b0;
            e_wdata    <= 32'h0000_0000;
            e_size     <= 2'd0;
            err        <= 1'b0;
        end else begin
            e_start <= 1'b0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_s != 2'b00) begin
                        gnt_port_r <= pick_d_s ? PORT_D : PORT_I;
                        if (illegal_s) begin
                            // Rejected without touching the engine; respond immediately.
                            state_r <= ST_ERR;
                            err     <= 1'b1;
                            if (pick_d_s) begin
                                d_done  <= 1'b1;
                                d_rdata <= 32'h0000_0000;
                            end else begin
                                i_done  <= 1'b1;
                                i_rdata <= 32'h0000_0000;
                            end
                        end else begin
                            state_r <= ST_ISSUE;
                            e_start <= 1'b1;
                            e_sel   <= req_sel_s;
                            e_addr  <= req_addr_s[WIN_BITS-1:0];
                            e_we    <= req_we_s;
                            e_wdata <= req_wdata_s;
                            e_size  <= req_size_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (e_done) begin
                        state_r <= ST_DONE;
                        if (gnt_port_r == PORT_D) begin
                            d_done  <= 1'b1;
                            d_rdata <= e_rdata;
                        end else begin
                            i_done  <= 1'b1;
                            i_rdata <= e_rdata;
                        end
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    e_sel   <= 1'b0;
                    e_addr  <= 24'h00_0000;
                    e_we    <= 1'b0;
                    e_wdata <= 32'h0000_0000;
                    e_size  <= 2'd0;
                    if (HAS_GAP) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= GAP_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 4'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                ST_ERR: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    gap_cnt_r <= 4'd0;
                    e_sel     <= 1'b0;
                    e_addr    <= 24'h00_0000;
                    e_we      <= 1'b0;
                    e_wdata   <= 32'h0000_0000;
                    e_size    <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/qspi_bus_arbiter.md
# qspi_bus_arbiter

Two-port arbiter and sequencer for the SoC's single shared quad-SPI engine. Its requesters are the core instruction fetch port (read-only) and the core data port (read/write). It decodes each request to flash or PSRAM, grants the bus round-robin and issues exactly one engine transaction per grant. It enforces a chip-select idle gap between transactions and returns data and a completion pulse to the granted requester. It sits between the core-facing memory controller logic and the SPI engine that drives `flash_cs_n`, `ram_cs_n`, `spi_sclk` and `spi_io_*`.

## Interface
- `FLASH_BASE_ADDR`, 32'h00000000, base of the 16 MiB flash window
- `PSRAM_BASE_ADDR`, 32'h01000000, base of the 16 MiB PSRAM window
- `CS_GAP`, 2, idle cycles between `e_done` and the next `e_start` (0..15)

Ports:
- `clk`  in  1  clock; one clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `i_req`  in  1  instruction request (level)
- `i_addr`  in  32  instruction address
- `i_rdata`  out  32  fetched word
- `i_done`  out  1  one-cycle completion pulse
- `d_req`  in  1  data request (level)
- `d_addr`  in  32  data address
- `d_we`  in  1  write when 1
- `d_wdata`  in  32  write data
- `d_size`  in  2  access size: 0 = byte, 1 = half, 2 = word (3 is treated as word)
- `d_rdata`  out  32  read data
- `d_done`  out  1  one-cycle completion pulse
- `e_start`  out  1  one-cycle engine start pulse
- `e_sel`  out  1  0 = flash, 1 = PSRAM
- `e_addr`  out  24  device byte address
- `e_we`, `e_wdata[31:0]`, `e_size[1:0]`  out  transaction payload
- `e_done`  in  1  engine completion pulse
- `e_rdata`  in  32  engine read data, valid with `e_done`
- `err`  out  1  one-cycle pulse on decode or access error

## Operation
- **Requester contract:** hold req and payload stable until the matching done. A req still high in the cycle after done is a new request.
- **Decode:**
  - An address in [base, base+2^24) selects that device; `e_addr = addr[23:0]`.
  - Any other address is a decode error.
  - A data write to flash is an access error.
- **Arbitration:** evaluated only in IDLE.
  - A single requester wins.
  - If both request, the port not granted last wins.
  - `last_grant` resets to data, so instruction wins the first tie.
- **States:**
  - IDLE: a request is present → latch payload and grant → ISSUE, or ERR if the request is illegal.
  - ISSUE: `e_start = 1` for one cycle with payload driven → BUSY.
  - BUSY: wait for `e_done`. On `e_done`, capture `e_rdata` → DONE.
  - DONE: pulse the granted port's done with its rdata → GAP if `CS_GAP > 0`, else IDLE.
  - GAP: count `CS_GAP` cycles → IDLE.
  - ERR: pulse the granted port's done and `err`, rdata = 0, no `e_start` → IDLE (no gap).
- **Held outputs:** `e_sel`, `e_addr`, `e_we`, `e_wdata` and `e_size` hold their latched values from ISSUE through DONE. They are 0 in IDLE.
- **Instruction accesses:** always `e_we = 0` and `e_size = 2`.
- **Ignored engine pulses:** `e_done` is ignored outside BUSY.
- **Data visibility:** `i_rdata` and `d_rdata` hold their last value until the next done for that port.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, the gap counter is 0 and `last_grant` is data. Reset asserted mid-transaction aborts immediately with no done pulse. The engine shares `rst_n`.
- **Request to start:** req sampled in cycle N (IDLE) gives `e_start` in N+1.
- **Engine to completion:** `e_done` in cycle M gives done in M+1.
- **Minimum legal latency:** req to done is 4 cycles when `e_done` arrives in the cycle after `e_start`.
- **Back-to-back spacing:** the next `e_start` is no earlier than M + 1 + `CS_GAP` + 2.
- **Error latency:** req to done + `err` is 2 cycles.
- **Arrival during a transaction:** requests arriving during ISSUE, BUSY, DONE or GAP wait. A req dropped before grant is forgotten (a protocol violation, not checked).
- **Fairness:** with both requesters held continuously, grants strictly alternate I, D, I, D.

## Structure
- The shared package `qspi_pkg` holds:
  - the state encoding (IDLE, ISSUE, BUSY, DONE, GAP, ERR)
  - `SEL_FLASH` / `SEL_PSRAM`
  - the size encodings `SZ_B`, `SZ_H`, `SZ_W`
  - the 24-bit window width constant
- One sub-module, `rr_arb2`: 2-input round-robin picker with registered `last_grant`, and update enable on grant.
- Decode, FSM, gap counter and payload registers stay in `qspi_bus_arbiter`.

## Test plan
- Instruction read: `i_req`, `i_addr = 0x00000100`, engine returns 0xDEADBEEF 3 cycles after start → `e_sel = 0`, `e_addr = 0x000100`, `i_done` one cycle with `i_rdata = 0xDEADBEEF`.
- Data write: `d_addr = 0x01000020`, `d_we = 1`, `d_wdata = 0x12345678`, `d_size = 2` → `e_sel = 1`, `e_addr = 0x000020`, `e_we = 1`, then `d_done`; next `e_start` no earlier than 2 + `CS_GAP` cycles after `d_done`.
- Simultaneous `i_req` and `d_req` held continuously from reset for 4 grants → grant order I, D, I, D. Exactly one done per transaction, never both ports in the same cycle.
- Errors: data write to 0x00000010 (flash), and data read from 0x40000000 → each gives `d_done` + `err` 2 cycles after req, `d_rdata = 0`, no `e_start`.
- Reset mid-op: assert `rst_n = 0` during BUSY, deassert, then send a stray `e_done` → no done, all outputs 0. A fresh `i_req` then completes normally.
